// File: rtl/rca_pipe_adder.sv
// Pipelined add/subtract built from STAGES registered ripple segments, with valid/ready on both sides.
// Define RCA_OVF_FLAG_EN to add the registered two's-complement overflow output ovf.
module rca_pipe_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef RCA_OVF_FLAG_EN
  ,
  output logic             ovf
`endif
);

  localparam int CHUNK = WIDTH / STAGES;

  logic                         advance;
  logic [STAGES-1:0][WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
  logic [STAGES-1:0]            c_q, c_d, v_q, v_d;
`ifdef RCA_OVF_FLAG_EN
  logic                         ovf_q, ovf_d;
`endif

  // One global enable: the whole pipe moves only when the output slot is free or being taken.
  assign advance  = !v_q[STAGES-1] || out_ready;
  assign in_ready = advance;

  always_comb begin : stage_comb
    logic [WIDTH-1:0] src_a, src_b, src_s;
    logic             src_c, src_v;
    logic [CHUNK:0]   part;
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    a_d   = '0;
    b_d   = '0;
    s_d   = '0;
    c_d   = '0;
    v_d   = '0;
`ifdef RCA_OVF_FLAG_EN
    ovf_d = 1'b0;
`endif
    src_a = a;
    src_b = b ^ {WIDTH{sub}};
    src_c = cin ^ sub;
    src_s = '0;
    src_v = in_valid;
    part  = '0;
    for (int k = 0; k < STAGES; k++) begin
      part = {1'b0, src_a[k*CHUNK +: CHUNK]} + {1'b0, src_b[k*CHUNK +: CHUNK]}
           + {{CHUNK{1'b0}}, src_c};
      a_d[k]                 = src_a;
      b_d[k]                 = src_b;
      s_d[k]                 = src_s;
      s_d[k][k*CHUNK +: CHUNK] = part[CHUNK-1:0];
      c_d[k]                 = part[CHUNK];
      v_d[k]                 = src_v;
`ifdef RCA_OVF_FLAG_EN
      // Carry into the MSB recovered from its sum bit: s = a ^ b ^ c_in.
      if (k == STAGES-1)
        ovf_d = (src_a[WIDTH-1] ^ src_b[WIDTH-1] ^ part[CHUNK-1]) ^ part[CHUNK];
`endif
      src_a = a_q[k];
      src_b = b_q[k];
      src_c = c_q[k];
      src_s = s_q[k];
      src_v = v_q[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: pipeline state is small, so all of it is reset to keep outputs at zero after reset.
      a_q   <= '0;
      b_q   <= '0;
      s_q   <= '0;
      c_q   <= '0;
      v_q   <= '0;
`ifdef RCA_OVF_FLAG_EN
      ovf_q <= 1'b0;
`endif
    end else if (advance) begin
      // NOTE: state registers use non-blocking assignments so every stage sees pre-edge values.
      v_q <= v_d;
      for (int k = 0; k < STAGES; k++) begin
        if (v_d[k]) begin
          a_q[k] <= a_d[k];
          b_q[k] <= b_d[k];
          s_q[k] <= s_d[k];
          c_q[k] <= c_d[k];
        end
      end
`ifdef RCA_OVF_FLAG_EN
      if (v_d[STAGES-1]) ovf_q <= ovf_d;
`endif
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
`ifdef RCA_OVF_FLAG_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_rca_pipe_adder.sv
// Directed bench for rca_pipe_adder: a 16-bit/4-stage and an 8-bit/1-stage instance.
module tb_rca_pipe_adder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        in_valid16, in_ready16, cin16, sub16, out_valid16, out_ready16, cout16;
  logic [15:0] a16, b16, sum16;
  logic        in_valid8, in_ready8, cin8, sub8, out_valid8, out_ready8, cout8;
  logic [7:0]  a8, b8, sum8;
`ifdef RCA_OVF_FLAG_EN
  logic        ovf16, ovf8;
`endif

  rca_pipe_adder #(.WIDTH(16), .STAGES(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .cin(cin16), .sub(sub16), .out_valid(out_valid16),
    .out_ready(out_ready16), .sum(sum16), .cout(cout16)
`ifdef RCA_OVF_FLAG_EN
    , .ovf(ovf16)
`endif
  );

  rca_pipe_adder #(.WIDTH(8), .STAGES(1)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8), .sub(sub8), .out_valid(out_valid8),
    .out_ready(out_ready8), .sum(sum8), .cout(cout8)
`ifdef RCA_OVF_FLAG_EN
    , .ovf(ovf8)
`endif
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Plain-arithmetic reference; overflow from operand/result signs.
  task automatic model(input int w, input logic [15:0] ma, input logic [15:0] mb,
                       input logic mc, input logic ms,
                       output logic [15:0] es, output logic ec, output logic eo);
    logic [31:0] mask, bm, t;
    mask = (32'd1 << w) - 32'd1;
    bm   = ms ? (~{16'd0, mb} & mask) : {16'd0, mb};
    t    = {16'd0, ma} + bm + {31'd0, mc ^ ms};
    es   = t[15:0] & mask[15:0];
    ec   = t[w];
    eo   = (ma[w-1] == bm[w-1]) && (es[w-1] != ma[w-1]);
  endtask

  task automatic run16(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                       input logic tc, input logic ts,
                       input logic [15:0] es, input logic ec, input logic eo);
    int lat;
    a16 = ta; b16 = tb; cin16 = tc; sub16 = ts; in_valid16 = 1'b1;
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    a16 = ~ta; b16 = ~tb; cin16 = ~tc; sub16 = ~ts;
    lat = 1;
    while (!out_valid16 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, lat, 4);
    check({tag, " sum"}, {16'd0, sum16}, {16'd0, es});
    check({tag, " cout"}, {31'd0, cout16}, {31'd0, ec});
`ifdef RCA_OVF_FLAG_EN
    check({tag, " ovf"}, {31'd0, ovf16}, {31'd0, eo});
`else
    if (eo === 1'bx) $display("note: %s overflow expectation unknown", tag);
`endif
    @(posedge clk); #1;
  endtask

  task automatic run8(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                      input logic tc, input logic ts,
                      input logic [7:0] es, input logic ec, input logic eo);
    int lat;
    a8 = ta; b8 = tb; cin8 = tc; sub8 = ts; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    lat = 1;
    while (!out_valid8 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, lat, 1);
    check({tag, " sum"}, {24'd0, sum8}, {24'd0, es});
    check({tag, " cout"}, {31'd0, cout8}, {31'd0, ec});
`ifdef RCA_OVF_FLAG_EN
    check({tag, " ovf"}, {31'd0, ovf8}, {31'd0, eo});
`else
    if (eo === 1'bx) $display("note: %s overflow expectation unknown", tag);
`endif
    @(posedge clk); #1;
  endtask

  logic [15:0] bp_a [8], bp_b [8], bp_s [8];
  logic        bp_c [8], bp_m [8], bp_co [8], bp_o [8];

  initial begin
    int          sent, got, stale, wait_cyc;
    logic        stall;
    logic [15:0] prev_sum, es;
    logic        ec, eo;

    rst_n = 1'b0;
    in_valid16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0; out_ready16 = 1'b1;
    in_valid8  = 1'b0; a8  = '0; b8  = '0; cin8  = 1'b0; sub8  = 1'b0; out_ready8  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid16", {31'd0, out_valid16}, 0);
    check("reset in_ready16", {31'd0, in_ready16}, 1);
    check("reset sum16", {16'd0, sum16}, 0);
    check("reset cout16", {31'd0, cout16}, 0);
    check("reset out_valid8", {31'd0, out_valid8}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Hand-computed 16-bit vectors.
    run16("add wrap",     16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run16("sub 5-7",      16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run16("sub 5-7-1",    16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0);
    run16("add pos ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run16("sub neg ovf",  16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run16("add cin",      16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
    run16("sub equal",    16'hABCD, 16'hABCD, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    run16("chunk carry",  16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    run16("all ones cin", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0);

    // Backpressure: 8 back-to-back beats, consumer stalls for 3 cycles mid-stream.
    for (int i = 0; i < 8; i++) begin
      bp_a[i] = 16'($urandom); bp_b[i] = 16'($urandom);
      bp_c[i] = 1'($urandom);  bp_m[i] = 1'($urandom);
      model(16, bp_a[i], bp_b[i], bp_c[i], bp_m[i], es, ec, eo);
      bp_s[i] = es; bp_co[i] = ec; bp_o[i] = eo;
    end
    sent = 0; got = 0; prev_sum = '0;
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      stall       = (cyc >= 5 && cyc < 8);
      out_ready16 = !stall;
      in_valid16  = (sent < 8);
      if (sent < 8) begin
        a16 = bp_a[sent]; b16 = bp_b[sent]; cin16 = bp_c[sent]; sub16 = bp_m[sent];
      end
      #1;
      check("bp in_ready", {31'd0, in_ready16}, {31'd0, !stall});
      if (out_valid16) begin
        if (stall && cyc > 5) check("bp hold", {16'd0, sum16}, {16'd0, prev_sum});
        check("bp sum", {16'd0, sum16}, {16'd0, bp_s[got]});
        check("bp cout", {31'd0, cout16}, {31'd0, bp_co[got]});
`ifdef RCA_OVF_FLAG_EN
        check("bp ovf", {31'd0, ovf16}, {31'd0, bp_o[got]});
`endif
        prev_sum = sum16;
        if (!stall) got++;
      end
      if (in_valid16 && in_ready16) sent++;
      @(posedge clk); #1;
    end
    in_valid16 = 1'b0; out_ready16 = 1'b1;
    check("bp count", got, 8);

    // Reset while two beats are in flight.
    a16 = 16'h1111; b16 = 16'h2222; cin16 = 1'b0; sub16 = 1'b0; in_valid16 = 1'b1;
    @(posedge clk); #1;
    a16 = 16'h3333;
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    wait_cyc = 0;
    while (!out_valid16 && wait_cyc < 10) begin
      @(posedge clk); #1;
      wait_cyc++;
    end
    check("rst pre out_valid", {31'd0, out_valid16}, 1);
    rst_n = 1'b0;
    #1;
    check("rst out_valid", {31'd0, out_valid16}, 0);
    check("rst in_ready", {31'd0, in_ready16}, 1);
    check("rst sum", {16'd0, sum16}, 0);
    check("rst cout", {31'd0, cout16}, 0);
`ifdef RCA_OVF_FLAG_EN
    check("rst ovf", {31'd0, ovf16}, 0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid16) stale++;
    end
    check("rst stale", stale, 0);
    run16("post rst", 16'h0102, 16'h0304, 1'b0, 1'b0, 16'h0406, 1'b0, 1'b0);

    // Single-stage 8-bit instance.
    run8("w8 wrap", 8'hF0, 8'h10, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    run8("w8 sub",  8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      logic [7:0] ra, rb;
      logic       rc, rm;
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom); rm = 1'($urandom);
      model(8, {8'd0, ra}, {8'd0, rb}, rc, rm, es, ec, eo);
      run8("w8 sweep", ra, rb, rc, rm, es[7:0], ec, eo);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
